// File: rtl/conv_mac_engine_if.sv
// Handshake bundle for conv_mac_engine: channel-beat input stream
// (in_*, bias, relu_en) and result output stream (out_*).
// master: window/weight fetch + downstream side; slave: the engine.
interface conv_mac_engine_if #(
   parameter int DW = 16,
   parameter int K  = 3,
   parameter int OW = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_last;
   logic [K*K*DW-1:0]     in_pix;
   logic [K*K*DW-1:0]     in_wgt;
   logic [DW-1:0]         bias;
   logic                  relu_en;
   logic                  out_valid;
   logic                  out_ready;
   logic [OW-1:0]         out_data;
   logic                  out_sat;

   modport master (
      output in_valid, in_last, in_pix, in_wgt,
      output bias, relu_en, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );

   modport slave (
      input  in_valid, in_last, in_pix, in_wgt,
      input  bias, relu_en, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );
endinterface

// File: rtl/conv_mac_engine.sv
// Streaming KxK multi-channel MAC: accumulate channel beats, add bias,
// requantise (x Q, rounding >>> SHIFT), optional ReLU, saturate to OW.
// Ports: clk, rst (sync, active high), bus (slave modport: beat input
// stream and result output stream), err (sticky channel overflow),
// busy (high outside IDLE).
module conv_mac_engine #(
   parameter int              DW     = 16,
   parameter int              K      = 3,
   parameter int              CH_MAX = 16,
   parameter int              ACC_W  = 48,
   parameter int              QW     = 32,
   parameter logic [QW-1:0]   Q      = QW'(2014687024),
   parameter int              SHIFT  = 32,
   parameter int              OW     = 8
) (
   input  logic               clk,
   input  logic               rst,
   conv_mac_engine_if.slave   bus,
   output logic               err,
   output logic               busy
);

   localparam int NE  = K * K;
   localparam int PW  = ACC_W + QW + 1;
   // one guard bit so the rounding add cannot wrap
   localparam int RW  = PW + 1;
   localparam int CW  = $clog2(CH_MAX + 1);
   localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

   typedef enum logic [2:0] {
      S_IDLE, S_ACCUM, S_BIAS, S_SCALE, S_ACT, S_OUT
   } state_t;

   state_t                    r_state;
   state_t                    w_next;

   logic signed [ACC_W-1:0]   r_acc;
   logic signed [PW-1:0]      r_prod;
   logic [CW-1:0]             r_cnt;
   logic signed [DW-1:0]      r_bias;
   logic                      r_relu;
   logic [OW-1:0]             r_out_data;
   logic                      r_out_sat;
   logic                      r_out_valid;
   logic                      r_err;

   logic                      w_in_ready;
   logic                      w_accept;
   logic [CW-1:0]             w_cnt_nx;
   logic signed [ACC_W-1:0]   w_prod [NE];
   logic signed [ACC_W-1:0]   w_sum;
   logic signed [PW-1:0]      w_accx;
   logic signed [PW-1:0]      w_qx;
   logic signed [RW-1:0]      w_rnd_add;
   logic signed [RW-1:0]      w_pre;
   logic signed [RW-1:0]      w_sh;
   logic signed [RW-1:0]      w_rl;
   logic signed [RW-1:0]      w_max;
   logic signed [RW-1:0]      w_min;
   logic signed [RW-1:0]      w_cl;
   logic                      w_sat;

   // ---------------- window dot product ----------------
   for (genvar gi = 0; gi < NE; gi++) begin : g_mul
      logic signed [DW-1:0]   w_a;
      logic signed [DW-1:0]   w_b;
      logic signed [2*DW-1:0] w_p;
      assign w_a = bus.in_pix[gi*DW +: DW];
      assign w_b = bus.in_wgt[gi*DW +: DW];
      assign w_p = w_a * w_b;
      assign w_prod[gi] = ACC_W'(w_p);
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < NE; i++) begin
         w_sum = w_sum + w_prod[i];
      end
   end

   assign w_cnt_nx = r_cnt + CW'(1);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept)
               w_next = bus.in_last ? S_BIAS : S_ACCUM;
         end
         S_ACCUM: begin
            if (w_accept &&
                (bus.in_last || w_cnt_nx == CW'(CH_MAX)))
               w_next = S_BIAS;
         end
         S_BIAS:  w_next = S_SCALE;
         S_SCALE: w_next = S_ACT;
         S_ACT:   w_next = S_OUT;
         S_OUT: begin
            if (bus.out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_in_ready = 1'b0;
      busy       = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            w_in_ready = !rst;
            busy       = 1'b0;
         end
         S_ACCUM: w_in_ready = !rst;
         default: ;
      endcase
   end

   assign w_accept = bus.in_valid && w_in_ready;

   // ---------------- requantise / activate / clamp ----------------
   assign w_accx    = PW'(r_acc);
   assign w_qx      = PW'({1'b0, Q});
   assign w_rnd_add = (SHIFT > 0) ? (RW'(1) << RSH) : '0;
   assign w_pre     = RW'(r_prod) + w_rnd_add;
   assign w_sh      = w_pre >>> SHIFT;
   assign w_rl      = (r_relu && w_sh < 0) ? '0 : w_sh;
   assign w_max     = RW'((64'sd1 <<< (OW - 1)) - 64'sd1);
   assign w_min     = ~w_max;

   always_comb begin
      w_cl  = w_rl;
      w_sat = 1'b0;
      if (w_rl > w_max) begin
         w_cl  = w_max;
         w_sat = 1'b1;
      end else if (w_rl < w_min) begin
         w_cl  = w_min;
         w_sat = 1'b1;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc       <= '0;
         r_prod      <= '0;
         r_cnt       <= '0;
         r_bias      <= '0;
         r_relu      <= 1'b0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_acc  <= w_sum;
                  r_bias <= bus.bias;
                  r_relu <= bus.relu_en;
                  r_cnt  <= CW'(1);
               end
            end
            S_ACCUM: begin
               if (w_accept) begin
                  r_acc <= r_acc + w_sum;
                  r_cnt <= w_cnt_nx;
                  // forced close without in_last: flag overflow
                  if (!bus.in_last && w_cnt_nx == CW'(CH_MAX))
                     r_err <= 1'b1;
               end
            end
            S_BIAS:  r_acc  <= r_acc + ACC_W'(r_bias);
            S_SCALE: r_prod <= w_accx * w_qx;
            S_ACT: begin
               r_out_data  <= OW'(w_cl);
               r_out_sat   <= w_sat;
               r_out_valid <= 1'b1;
            end
            S_OUT: begin
               if (bus.out_ready) r_out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_sat   = r_out_sat;
   assign err           = r_err;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine: four parameter variants share
// one stimulus driver, selected by sel.
module tb_conv_mac_engine;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         tv, tlast, trelu, tordy;
   logic [143:0] tpix, twgt;
   logic [15:0]  tbias;
   int           sel;
   int           checks = 0;
   int           errors = 0;

   conv_mac_engine_if #(.DW(16), .K(3), .OW(8)) if0 ();
   conv_mac_engine_if #(.DW(16), .K(3), .OW(8)) if1 ();
   conv_mac_engine_if #(.DW(16), .K(3), .OW(8)) if2 ();
   conv_mac_engine_if #(.DW(16), .K(3), .OW(8)) if3 ();

   assign if0.in_valid = tv && sel == 0;
   assign if1.in_valid = tv && sel == 1;
   assign if2.in_valid = tv && sel == 2;
   assign if3.in_valid = tv && sel == 3;
   assign if0.out_ready = (sel == 0) ? tordy : 1'b1;
   assign if1.out_ready = (sel == 1) ? tordy : 1'b1;
   assign if2.out_ready = (sel == 2) ? tordy : 1'b1;
   assign if3.out_ready = (sel == 3) ? tordy : 1'b1;
   assign if0.in_last = tlast; assign if1.in_last = tlast;
   assign if2.in_last = tlast; assign if3.in_last = tlast;
   assign if0.in_pix = tpix;   assign if1.in_pix = tpix;
   assign if2.in_pix = tpix;   assign if3.in_pix = tpix;
   assign if0.in_wgt = twgt;   assign if1.in_wgt = twgt;
   assign if2.in_wgt = twgt;   assign if3.in_wgt = twgt;
   assign if0.bias = tbias;    assign if1.bias = tbias;
   assign if2.bias = tbias;    assign if3.bias = tbias;
   assign if0.relu_en = trelu; assign if1.relu_en = trelu;
   assign if2.relu_en = trelu; assign if3.relu_en = trelu;

   logic err0, err1, err2, err3;
   logic busy0, busy1, busy2, busy3;

   conv_mac_engine #(.Q(1), .SHIFT(0)) u0 (
      .clk(clk), .rst(rst), .bus(if0.slave), .err(err0), .busy(busy0));
   conv_mac_engine u1 (
      .clk(clk), .rst(rst), .bus(if1.slave), .err(err1), .busy(busy1));
   conv_mac_engine #(.Q(1), .SHIFT(2)) u2 (
      .clk(clk), .rst(rst), .bus(if2.slave), .err(err2), .busy(busy2));
   conv_mac_engine #(.Q(1), .SHIFT(0), .CH_MAX(4)) u3 (
      .clk(clk), .rst(rst), .bus(if3.slave), .err(err3), .busy(busy3));

   logic              m_iready, m_ovalid, m_osat, m_err, m_busy;
   logic signed [7:0] m_odata;

   always_comb begin
      case (sel)
         1: begin
            m_iready = if1.in_ready; m_ovalid = if1.out_valid;
            m_odata = if1.out_data;  m_osat = if1.out_sat;
            m_err = err1;            m_busy = busy1;
         end
         2: begin
            m_iready = if2.in_ready; m_ovalid = if2.out_valid;
            m_odata = if2.out_data;  m_osat = if2.out_sat;
            m_err = err2;            m_busy = busy2;
         end
         3: begin
            m_iready = if3.in_ready; m_ovalid = if3.out_valid;
            m_odata = if3.out_data;  m_osat = if3.out_sat;
            m_err = err3;            m_busy = busy3;
         end
         default: begin
            m_iready = if0.in_ready; m_ovalid = if0.out_valid;
            m_odata = if0.out_data;  m_osat = if0.out_sat;
            m_err = err0;            m_busy = busy0;
         end
      endcase
   end

   typedef struct {
      string nm;
      int    dut;
      int    nb;
      int    pv;
      int    wv;
      bit    only0;
      int    b;
      bit    relu;
      int    exp_d;
      bit    exp_s;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [143:0] mkvec(input int v, input bit only0);
      logic [143:0] r;
      r = '0;
      for (int i = 0; i < 9; i++)
         if (!only0 || i == 0) r[i*16 +: 16] = 16'(v);
      return r;
   endfunction

   // drives one beat; returns at +1 after its accept edge
   task automatic send_beat(input bit last);
      int n;
      n = 0;
      tv = 1'b1;
      tlast = last;
      while (!m_iready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("accept_timeout", int'(n >= 20), 0);
      @(posedge clk); #1;
      tv = 1'b0;
      tlast = 1'b0;
   endtask

   task automatic run_txn(input int d, input int nb, input int pv,
                          input int wv, input bit only0, input int b,
                          input bit relu, input bit nolast,
                          output int od, output bit os, output int lat);
      sel = d;
      tpix = mkvec(pv, only0);
      twgt = mkvec(wv, only0);
      tbias = 16'(b);
      trelu = relu;
      for (int i = 0; i < nb; i++) send_beat(!nolast && i == nb - 1);
      lat = 0;
      while (!m_ovalid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      od = int'(m_odata);
      os = m_osat;
   endtask

   int  od, lat;
   bit  os, seen;
   logic signed [7:0] held;

   initial begin
      tbl[0] = '{"q1_basic",  0, 1,  2,  3, 0, 10, 0,   64, 0};
      tbl[1] = '{"dflt_q",    1, 1,  2,  3, 0, 10, 0,   30, 0};
      tbl[2] = '{"sat_pos",   0, 3,  2,  3, 0,  0, 0,  127, 1};
      tbl[3] = '{"neg_norelu",0, 1,  1, -5, 0,  0, 0,  -45, 0};
      tbl[4] = '{"neg_relu",  0, 1,  1, -5, 0,  0, 1,    0, 0};
      tbl[5] = '{"shr_pos",   2, 1,  1,  6, 1,  0, 0,    2, 0};
      tbl[6] = '{"shr_neg",   2, 1,  1, -6, 1,  0, 0,   -1, 0};
      tbl[7] = '{"sat_neg",   0, 3, -2,  3, 0,  0, 0, -128, 1};

      rst = 1'b1; tv = 1'b0; tlast = 1'b0; trelu = 1'b0;
      tordy = 1'b1; tpix = '0; twgt = '0; tbias = '0; sel = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(m_iready), 0);
      chk("rst_out_valid", int'(m_ovalid), 0);
      chk("rst_out_data", int'(m_odata), 0);
      chk("rst_out_sat", int'(m_osat), 0);
      chk("rst_err", int'(m_err), 0);
      chk("rst_busy", int'(m_busy), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", int'(m_iready), 1);

      for (int k = 0; k < 8; k++) begin
         run_txn(tbl[k].dut, tbl[k].nb, tbl[k].pv, tbl[k].wv,
                 tbl[k].only0, tbl[k].b, tbl[k].relu, 1'b0,
                 od, os, lat);
         chk({tbl[k].nm, "_lat"}, lat, 3);
         chk({tbl[k].nm, "_data"}, od, tbl[k].exp_d);
         chk({tbl[k].nm, "_sat"}, int'(os), int'(tbl[k].exp_s));
         @(posedge clk); #1;
         chk({tbl[k].nm, "_drain"}, int'(m_ovalid), 0);
         chk({tbl[k].nm, "_ready"}, int'(m_iready), 1);
      end

      // backpressure: result held while out_ready low
      tordy = 1'b0;
      run_txn(2, 1, 1, 6, 1'b1, 0, 1'b0, 1'b0, od, os, lat);
      chk("hold_data", od, 2);
      held = m_odata;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold_stable", int'(m_odata), int'(held));
         chk("hold_valid", int'(m_ovalid), 1);
         chk("hold_in_ready", int'(m_iready), 0);
      end
      tordy = 1'b1;
      @(posedge clk); #1;
      chk("release_in_ready", int'(m_iready), 1);
      chk("release_valid", int'(m_ovalid), 0);

      // reset mid-accumulation discards the partial result
      sel = 0;
      tpix = mkvec(2, 1'b0);
      twgt = mkvec(3, 1'b0);
      tbias = 16'(10);
      trelu = 1'b0;
      send_beat(1'b0);
      send_beat(1'b0);
      chk("mid_busy", int'(m_busy), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", int'(m_iready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         seen = seen | m_ovalid;
      end
      chk("mid_rst_no_out", int'(seen), 0);
      chk("mid_rst_busy", int'(m_busy), 0);
      run_txn(0, 1, 2, 3, 1'b0, 10, 1'b0, 1'b0, od, os, lat);
      chk("after_rst_lat", lat, 3);
      chk("after_rst_data", od, 64);
      @(posedge clk); #1;

      // channel overflow at CH_MAX=4 without in_last
      sel = 3;
      #1;
      chk("ovf_err_before", int'(m_err), 0);
      run_txn(3, 4, 1, 1, 1'b0, 0, 1'b0, 1'b1, od, os, lat);
      chk("ovf_lat", lat, 3);
      chk("ovf_data", od, 36);
      chk("ovf_sat", int'(os), 0);
      chk("ovf_err", int'(m_err), 1);
      @(posedge clk); #1;
      chk("ovf_err_sticky", int'(m_err), 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_mac_engine.md
# conv_mac_engine

Parametrised successor to the fixed 3x3 convolution unit. It is a streaming K×K multi-channel multiply-accumulate engine: it accumulates one K×K window per input channel over a variable number of channels, then adds a bias. The result is requantised with scale Q and a rounding right shift, passed through an optional runtime ReLU and saturated to a signed OW-bit output. It sits between the window/weight fetch logic and the max-pooling stage, with valid/ready handshakes on both sides.

## Interface
- DW, 16: signed width of pixels, weights and bias
- K, 3: kernel side; a window is K*K elements
- CH_MAX, 16: maximum channel beats per result
- ACC_W, 48: signed accumulator width; must be ≥ 2*DW + clog2(K*K*CH_MAX) + 1
- QW, 32: unsigned width of Q
- Q, 2014687024: requantisation multiplier
- SHIFT, 32: arithmetic right shift after the Q multiply; 0 is allowed
- OW, 8: signed output width
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  channel beat valid
- in_ready  out  1  engine accepts a beat
- in_last  in  1  final channel beat of the current result
- in_pix  in  K*K*DW  window pixels, element i at [i*DW +: DW], signed
- in_wgt  in  K*K*DW  weights, same packing, signed
- bias  in  DW  signed bias; sampled on the first beat only
- relu_en  in  1  ReLU mode; sampled on the first beat only
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_data  out  OW  signed result
- out_sat  out  1  result was clamped; qualified by out_valid
- err  out  1  sticky channel-overflow flag; cleared only by rst
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ACCUM, BIAS, SCALE, ACT, OUT.
- in_ready = !rst && (state==IDLE || state==ACCUM).
- A beat is accepted when in_valid && in_ready.
- IDLE, on accept:
  - acc <= sum of K*K products in_pix[i]*in_wgt[i], each full-precision and sign-extended to ACC_W.
  - Latch bias and relu_en; chan_cnt <= 1.
  - Go to ACCUM, or to BIAS if in_last.
- ACCUM, on accept:
  - acc <= acc + sum of the K*K products; chan_cnt++.
  - Go to BIAS if in_last, or if this beat makes chan_cnt == CH_MAX. In the latter case without in_last, also set err.
  - A cycle with no beat holds all state.
- BIAS: acc <= acc + sign-extended bias; go to SCALE.
- SCALE: prod <= acc * Q, signed × unsigned, ACC_W+QW+1 bits; go to ACT.
- ACT:
  - r = (prod + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT (round half up).
  - If relu_en and r<0, then r=0.
  - Clamp r to [-2^(OW-1), 2^(OW-1)-1].
  - out_data <= clamped r; out_sat <= (clamp changed r); out_valid <= 1; go to OUT.
- OUT: hold out_data and out_sat stable. When out_ready, out_valid <= 0 and go to IDLE.
- Reset (synchronous, at any state, including mid-accumulation or while in OUT):
  - state=IDLE; acc, prod, chan_cnt, out_data, out_sat, out_valid and err become 0.
  - A partial accumulation is discarded and produces no output.
- Reset values: in_ready 0 while rst is high, 1 in the first cycle after; out_valid 0, out_data 0, out_sat 0, err 0, busy 0.

## Timing
- Input throughput is one beat per cycle during accumulation.
- Last beat accepted at edge E: BIAS completes at E+1, SCALE at E+2, ACT at E+3. out_valid is high from E+3.
- Single-channel latency: 3 cycles from the accept edge to out_valid.
- Result N+1 cannot start until result N leaves OUT. in_ready rises the cycle after the out_valid && out_ready edge.
- No combinational path from out_ready to in_ready.
- out_data and out_sat change only on the ACT→OUT edge and on rst.

## Test plan
- Q=1, SHIFT=0, one beat, pix all 2, wgt all 3, bias 10, relu_en 0 -> out_data 64, out_sat 0, out_valid 3 cycles after accept.
- Default Q/SHIFT, same stimulus -> out_data 30, out_sat 0.
- Q=1, SHIFT=0, three beats each summing 54, bias 0 -> out_data 127, out_sat 1.
- Q=1, SHIFT=0, pix all 1, wgt all -5, bias 0:
  - relu_en=0 -> out_data -45 (0xD3).
  - relu_en=1 -> out_data 0, out_sat 0.
- Q=1, SHIFT=2: acc 6 -> 2; acc -6 -> -1. Then hold out_ready low for 5 cycles -> out_data stable, in_ready 0. Raise out_ready -> in_ready 1 the next cycle.
- Reset boundaries:
  - rst after 2 of 3 beats -> no out_valid. The next single-beat transaction gives the correct value.
  - CH_MAX=4, send 4 beats with in_last low -> err=1 and a result is produced after beat 4.
